rtds_rx_checker: RTL and testbench

- Downstream consumer of the augmented-Aurora AXI-Stream master interface (m_axis_*), clocked by the Aurora user clock.
- Receives RTDS frames delimited by tlast and checks each frame's length and word contents against a fixed expected pattern (default two words: 32'h00000005, 32'h00000003, matching the periodic stimulus on the transmit side).
- Maintains saturating frame and error counters, a last-frame status flag, and a link-activity watchdog.
- Used for loopback and bring-up validation of the Aurora/RTDS link.

---
 rtl/rtds_rx_checker_pkg.sv | 15 +
 rtl/rtds_rx_checker_sat_counter.sv | 27 ++
 rtl/rtds_rx_checker.sv | 181 ++++++++++++++++++
 tb/tb_rtds_rx_checker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtds_rx_checker_pkg.sv
// Shared types and default constants for the RTDS receive-side frame checker.
package rtds_rx_checker_pkg;

  // Frame-tracking FSM states; S_DROP discards the tail of an over-long frame.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BODY = 2'b01,
    S_DROP = 2'b11
  } state_t;

  // Default expected frame pattern, matching the periodic transmit stimulus.
  localparam logic [31:0] DEF_EXP_WORD0 = 32'h0000_0005;
  localparam logic [31:0] DEF_EXP_WORD1 = 32'h0000_0003;

endpackage

// File: rtl/rtds_rx_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module rtds_rx_checker_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             user_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count increments, holding at all-ones; clear and reset both zero the count.
  always_ff @(posedge user_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge.
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/rtds_rx_checker.sv
// RTDS frame checker on the Aurora AXI-Stream master side: checks frame length
// and contents against a fixed pattern, keeps saturating counters, last-frame
// status and a link-activity watchdog.
module rtds_rx_checker
  import rtds_rx_checker_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    EXP_WORDS  = 2,
  parameter logic [DATA_WIDTH-1:0] EXP_WORD0  = DATA_WIDTH'(DEF_EXP_WORD0),
  parameter logic [DATA_WIDTH-1:0] EXP_WORD1  = DATA_WIDTH'(DEF_EXP_WORD1),
  parameter int                    MAX_WORDS  = 16,
  parameter int                    TIMEOUT_W  = 16
) (
  input  logic                  user_clk,
  input  logic                  reset,
  input  logic                  clear_counts,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [31:0]           frame_count,
  output logic [15:0]           len_err_count,
  output logic [15:0]           data_err_count,
  output logic                  link_up
);

  localparam int               IDX_W   = $clog2(MAX_WORDS + 1);
  localparam logic [IDX_W-1:0] LEN_EXP = IDX_W'(EXP_WORDS);
  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(MAX_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_data_bad;
  logic             r_ovf;
  logic             r_tready;
  logic             r_frame_done;
  logic             r_frame_ok;
  logic             r_link_up;
  // One bit wider than TIMEOUT_W so the MSB sets after exactly 2^TIMEOUT_W cycles.
  logic [TIMEOUT_W:0] r_wd;

  logic             w_accept;
  logic             w_complete;
  logic [IDX_W-1:0] w_idx_next;
  logic [IDX_W-1:0] w_final_len;
  logic             w_data_bad;
  logic             w_len_err;
  logic             w_inc_len;
  logic             w_inc_data;
  logic [TIMEOUT_W:0] w_wd_next;

  // Per-beat decode: frame length and content status as they stand after this beat.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_accept    = s_axis_tvalid && r_tready;
    w_complete  = w_accept && s_axis_tlast;
    w_idx_next  = r_idx + 1'b1;
    w_final_len = w_idx_next;
    w_data_bad  = r_data_bad;
    case (r_state)
      S_IDLE: begin
        w_final_len = IDX_ONE;
        w_data_bad  = (s_axis_tdata != EXP_WORD0);
      end
      S_BODY: begin
        w_data_bad = r_data_bad || ((r_idx == IDX_ONE) && (s_axis_tdata != EXP_WORD1));
      end
      default: begin
        w_data_bad = r_data_bad;
      end
    endcase
    // r_ovf is only ever set while in S_DROP and is cleared when it exits.
    w_len_err  = r_ovf || (w_final_len != LEN_EXP);
    w_inc_len  = w_complete && w_len_err;
    w_inc_data = w_complete && !w_len_err && w_data_bad;
  end

  // Frame-tracking FSM: word index and the sticky per-frame error flags.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_data_bad <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          r_idx      <= IDX_ONE;
          r_data_bad <= w_data_bad;
          r_ovf      <= 1'b0;
          r_state    <= s_axis_tlast ? S_IDLE : S_BODY;
        end
        S_BODY: begin
          r_idx      <= w_idx_next;
          r_data_bad <= w_data_bad;
          if (s_axis_tlast) begin
            r_state <= S_IDLE;
          end else if (w_idx_next == LEN_MAX) begin
            r_state <= S_DROP;
            r_ovf   <= 1'b1;
          end
        end
        default: begin
          if (s_axis_tlast) begin
            r_state <= S_IDLE;
            r_ovf   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Registered handshake and per-frame status outputs; a clear overrides a completion.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_tready     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
    end else begin
      r_tready     <= 1'b1;
      r_frame_done <= w_complete;
      if (clear_counts) begin
        r_frame_ok <= 1'b0;
      end else if (w_complete) begin
        r_frame_ok <= !w_len_err && !w_data_bad;
      end
    end
  end

  assign w_wd_next = r_wd + 1'b1;

  // Link watchdog: restarts on each completed frame, drops link_up once the MSB sets and holds.
  always_ff @(posedge user_clk) begin
    if (reset || clear_counts) begin
      r_wd      <= '0;
      r_link_up <= 1'b0;
    end else if (w_complete) begin
      r_wd      <= '0;
      r_link_up <= 1'b1;
    end else if (!r_wd[TIMEOUT_W]) begin
      r_wd <= w_wd_next;
      if (w_wd_next[TIMEOUT_W]) begin
        r_link_up <= 1'b0;
      end
    end
  end

  rtds_rx_checker_sat_counter #(.WIDTH(32)) u_frame_cnt (
    .user_clk (user_clk),
    .reset    (reset),
    .clr      (clear_counts),
    .inc      (w_complete),
    .count    (frame_count)
  );

  rtds_rx_checker_sat_counter #(.WIDTH(16)) u_len_err_cnt (
    .user_clk (user_clk),
    .reset    (reset),
    .clr      (clear_counts),
    .inc      (w_inc_len),
    .count    (len_err_count)
  );

  rtds_rx_checker_sat_counter #(.WIDTH(16)) u_data_err_cnt (
    .user_clk (user_clk),
    .reset    (reset),
    .clr      (clear_counts),
    .inc      (w_inc_data),
    .count    (data_err_count)
  );

  assign s_axis_tready = r_tready;
  assign frame_done    = r_frame_done;
  assign frame_ok      = r_frame_ok;
  assign link_up       = r_link_up;

endmodule

// File: tb/tb_rtds_rx_checker.sv
// Self-checking bench for rtds_rx_checker: directed phases from the test plan
// followed by randomized frames, all compared every cycle against a
// frame-level reference model.
module tb_rtds_rx_checker;

  localparam int          TW        = 8;
  localparam int          EXP_WORDS = 2;
  localparam int          MAX_WORDS = 16;
  localparam int          WD_LIMIT  = 1 << TW;
  localparam logic [31:0] W0        = 32'h0000_0005;
  localparam logic [31:0] W1        = 32'h0000_0003;

  logic        user_clk = 1'b0;
  logic        reset;
  logic        clear_counts;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        frame_done;
  logic        frame_ok;
  logic [31:0] frame_count;
  logic [15:0] len_err_count;
  logic [15:0] data_err_count;
  logic        link_up;

  rtds_rx_checker #(
    .DATA_WIDTH (32),
    .EXP_WORDS  (EXP_WORDS),
    .EXP_WORD0  (W0),
    .EXP_WORD1  (W1),
    .MAX_WORDS  (MAX_WORDS),
    .TIMEOUT_W  (TW)
  ) dut (
    .user_clk       (user_clk),
    .reset          (reset),
    .clear_counts   (clear_counts),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .frame_done     (frame_done),
    .frame_ok       (frame_ok),
    .frame_count    (frame_count),
    .len_err_count  (len_err_count),
    .data_err_count (data_err_count),
    .link_up        (link_up)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: whole-frame view of the link.
  logic [31:0] frame_q[$];
  logic [31:0] tx_q[$];
  bit          m_tready = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_ok     = 1'b0;
  bit          m_link   = 1'b0;
  int          m_since  = 0;
  logic [31:0] m_fc     = '0;
  logic [15:0] m_le     = '0;
  logic [15:0] m_de     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit rst, input bit clr, input bit v,
                            input logic [31:0] d, input bit l);
    bit comp;
    bit le;
    bit de;
    comp = 1'b0;
    le   = 1'b0;
    de   = 1'b0;
    if (rst) begin
      frame_q.delete();
      m_done   = 1'b0;
      m_ok     = 1'b0;
      m_fc     = '0;
      m_le     = '0;
      m_de     = '0;
      m_link   = 1'b0;
      m_since  = 0;
      m_tready = 1'b0;
    end else begin
      if (v && m_tready) begin
        frame_q.push_back(d);
        if (l) begin
          comp = 1'b1;
          le   = (frame_q.size() != EXP_WORDS);
          de   = !le && ((frame_q[0] != W0) || ((frame_q.size() > 1) && (frame_q[1] != W1)));
          frame_q.delete();
        end
      end
      m_done = comp;
      if (clr) begin
        m_fc    = '0;
        m_le    = '0;
        m_de    = '0;
        m_ok    = 1'b0;
        m_link  = 1'b0;
        m_since = 0;
      end else if (comp) begin
        if (m_fc != 32'hFFFF_FFFF) m_fc++;
        if (le && (m_le != 16'hFFFF)) m_le++;
        if (de && (m_de != 16'hFFFF)) m_de++;
        m_ok    = !le && !de;
        m_link  = 1'b1;
        m_since = 0;
      end else if (m_since < WD_LIMIT) begin
        m_since++;
        if (m_since == WD_LIMIT) m_link = 1'b0;
      end
      m_tready = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output with the model.
  task automatic cycle(input bit rst, input bit clr, input bit v,
                       input logic [31:0] d, input bit l);
    reset         = rst;
    clear_counts  = clr;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    @(posedge user_clk);
    #1;
    model_step(rst, clr, v, d, l);
    check("tready",   {31'b0, s_axis_tready}, {31'b0, m_tready});
    check("done",     {31'b0, frame_done},    {31'b0, m_done});
    check("ok",       {31'b0, frame_ok},      {31'b0, m_ok});
    check("link_up",  {31'b0, link_up},       {31'b0, m_link});
    check("fcount",   frame_count,            m_fc);
    check("len_err",  {16'b0, len_err_count}, {16'b0, m_le});
    check("data_err", {16'b0, data_err_count},{16'b0, m_de});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom_range(0, 1) == 1);
  endtask

  task automatic send_tx();
    for (int i = 0; i < tx_q.size(); i++) cycle(1'b0, 1'b0, 1'b1, tx_q[i], i == tx_q.size() - 1);
    tx_q.delete();
  endtask

  task automatic send2(input logic [31:0] a, input logic [31:0] b);
    tx_q.push_back(a);
    tx_q.push_back(b);
    send_tx();
  endtask

  task automatic do_clear();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    clear_counts  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("rst_tready", {31'b0, s_axis_tready}, 32'd0);
    check("rst_fcount", frame_count, 32'd0);
    idle(2);

    // Ten good frames with idle gaps
    for (int f = 0; f < 10; f++) begin
      send2(W0, W1);
      check("good_done", {31'b0, frame_done}, 32'd1);
      idle($urandom_range(1, 4));
    end
    check("good_fcount", frame_count, 32'd10);
    check("good_len_err", {16'b0, len_err_count}, 32'd0);
    check("good_data_err", {16'b0, data_err_count}, 32'd0);
    check("good_ok", {31'b0, frame_ok}, 32'd1);
    check("good_link", {31'b0, link_up}, 32'd1);
    do_clear();

    // Content error then a good frame
    send2(W0, 32'h4);
    idle(2);
    check("cerr_data_err", {16'b0, data_err_count}, 32'd1);
    check("cerr_ok", {31'b0, frame_ok}, 32'd0);
    send2(W0, W1);
    idle(1);
    check("cerr_ok_after", {31'b0, frame_ok}, 32'd1);
    check("cerr_fcount", frame_count, 32'd2);
    do_clear();

    // Length errors: short, long, and overrunning MAX_WORDS
    tx_q.push_back(W0);
    send_tx();
    tx_q.push_back(W0); tx_q.push_back(W1); tx_q.push_back(32'h7);
    send_tx();
    for (int i = 0; i < 20; i++) tx_q.push_back(i == 0 ? W0 : W1);
    send_tx();
    idle(2);
    check("lerr_len_err", {16'b0, len_err_count}, 32'd3);
    check("lerr_data_err", {16'b0, data_err_count}, 32'd0);
    check("lerr_fcount", frame_count, 32'd3);
    do_clear();

    // Back-to-back frames with tvalid held high
    cycle(1'b0, 1'b0, 1'b1, W0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, W1, 1'b1);
    check("b2b_done0", {31'b0, frame_done}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, W0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, W1, 1'b1);
    check("b2b_done1", {31'b0, frame_done}, 32'd1);
    idle(1);
    check("b2b_fcount", frame_count, 32'd2);
    do_clear();

    // Watchdog: link_up falls exactly 2^TW cycles after the completion cycle
    send2(W0, W1);
    check("wd_link_rise", {31'b0, link_up}, 32'd1);
    idle(WD_LIMIT - 1);
    check("wd_link_hold", {31'b0, link_up}, 32'd1);
    idle(1);
    check("wd_link_fall", {31'b0, link_up}, 32'd0);
    idle(5);
    send2(W0, W1);
    check("wd_link_again", {31'b0, link_up}, 32'd1);

    // Reset mid-frame: the partial frame is dropped, tready low during reset
    cycle(1'b0, 1'b0, 1'b1, W0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("mrst_tready", {31'b0, s_axis_tready}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, W1, 1'b1);
    idle(2);
    check("mrst_fcount", frame_count, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, W1, 1'b1);
    idle(1);
    check("mrst_tail_len_err", {16'b0, len_err_count}, 32'd1);

    // Clear coinciding with a completion: the frame is not counted
    cycle(1'b0, 1'b0, 1'b1, W0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, W1, 1'b1);
    check("clr_fcount", frame_count, 32'd0);
    check("clr_len_err", {16'b0, len_err_count}, 32'd0);
    check("clr_data_err", {16'b0, data_err_count}, 32'd0);
    idle(2);

    // Randomized frames with random lengths, contents and tvalid gaps
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : EXP_WORDS;
      for (int i = 0; i < len; i++) begin
        logic [31:0] w;
        case ($urandom_range(0, 5))
          0:       w = $urandom;
          1:       w = (i == 0) ? W1 : W0;
          default: w = (i == 0) ? W0 : W1;
        endcase
        while ($urandom_range(0, 3) == 0) idle(1);
        cycle(1'b0, ($urandom_range(0, 29) == 0), 1'b1, w, i == len - 1);
      end
      idle($urandom_range(0, 3));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
